// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: walks a byte-wide frame memory in BMP row layout,
// assembles BYTES_PER_PIXEL bytes per pixel and emits each pixel on a
// valid/ready stream with its coordinates, sync flags and frame count.
module pixel_frame_streamer #(
  parameter int WORD_SIZE       = 8,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int LOC_SIZE        = 16,
  parameter int ADDR_W          = 20
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 start,
  input  logic [LOC_SIZE-1:0]                  cfg_width,
  input  logic [LOC_SIZE-1:0]                  cfg_height,
  input  logic [ADDR_W-1:0]                    cfg_base,
  input  logic                                 cfg_bottom_up,
  output logic                                 mem_rd,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [WORD_SIZE-1:0]                 mem_rdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BYTES_PER_PIXEL*WORD_SIZE-1:0] out_data,
  output logic [LOC_SIZE-1:0]                  out_x,
  output logic [LOC_SIZE-1:0]                  out_y,
  output logic                                 out_hsync,
  output logic                                 out_vsync,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic [LOC_SIZE-1:0]                  frame
);

  localparam int DATA_W = BYTES_PER_PIXEL * WORD_SIZE;
  localparam int PROD_W = LOC_SIZE + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LAND  = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  localparam logic [1:0]          K_LAST = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [LOC_SIZE-1:0] ONE_L  = LOC_SIZE'(1);
  localparam logic [ADDR_W-1:0]   BPP_A  = ADDR_W'(BYTES_PER_PIXEL);
  localparam logic [PROD_W-1:0]   BPP_P  = PROD_W'(BYTES_PER_PIXEL);
  localparam logic [PROD_W-1:0]   PAD_P  = PROD_W'(3);

  logic [1:0]          state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [LOC_SIZE-1:0] x_q, x_d, y_q, y_d;
  logic [LOC_SIZE-1:0] w_q, w_d, h_q, h_d;
  logic                bu_q, bu_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic [ADDR_W-1:0]   pix_off_q, pix_off_d;
  logic                done_q, done_d;
  logic [LOC_SIZE-1:0] frame_q, frame_d;
  logic [DATA_W-1:0]   data_q;
  logic                rd_pend_q;
  logic [1:0]          rd_k_q;

  logic [PROD_W-1:0]   row_bytes_s, stride_s;
  logic [ADDR_W-1:0]   first_row_s;
  logic                last_s;

  // Row stride rounded up to a 4-byte boundary and the address of output row 0.
  always_comb begin
    row_bytes_s = PROD_W'(cfg_width) * BPP_P;
    stride_s    = (row_bytes_s + PAD_P) & ~PAD_P;
    if (cfg_bottom_up) begin
      first_row_s = cfg_base + ADDR_W'(cfg_height - ONE_L) * ADDR_W'(stride_s);
    end else begin
      first_row_s = cfg_base;
    end
  end

  assign last_s = (x_q == w_q - ONE_L) && (y_q == h_q - ONE_L);

  // Frame walk FSM: fetch bytes, land the last one, then hold the pixel until accepted.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    bu_d       = bu_q;
    stride_d   = stride_q;
    row_addr_d = row_addr_q;
    pix_off_d  = pix_off_q;
    done_d     = 1'b0;
    frame_d    = frame_q;
    case (state_q)
      S_IDLE: begin
        if (start && en) begin
          w_d        = cfg_width;
          h_d        = cfg_height;
          bu_d       = cfg_bottom_up;
          stride_d   = ADDR_W'(stride_s);
          row_addr_d = first_row_s;
          pix_off_d  = {ADDR_W{1'b0}};
          k_d        = 2'd0;
          x_d        = {LOC_SIZE{1'b0}};
          y_d        = {LOC_SIZE{1'b0}};
          if ((cfg_width == {LOC_SIZE{1'b0}}) || (cfg_height == {LOC_SIZE{1'b0}})) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (en) begin
          if (k_q == K_LAST) begin
            k_d     = 2'd0;
            state_d = S_LAND;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LAND: begin
        if (en) begin
          state_d = S_EMIT;
        end else begin
          state_d = S_LAND;
        end
      end
      S_EMIT: begin
        if (en && out_ready) begin
          if (last_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            frame_d = frame_q + ONE_L;
          end else begin
            state_d = S_FETCH;
            if (x_q == w_q - ONE_L) begin
              x_d       = {LOC_SIZE{1'b0}};
              y_d       = y_q + ONE_L;
              pix_off_d = {ADDR_W{1'b0}};
              if (bu_q) begin
                row_addr_d = row_addr_q - stride_q;
              end else begin
                row_addr_d = row_addr_q + stride_q;
              end
            end else begin
              x_d       = x_q + ONE_L;
              pix_off_d = pix_off_q + BPP_A;
            end
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, geometry and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= 2'd0;
      x_q        <= {LOC_SIZE{1'b0}};
      y_q        <= {LOC_SIZE{1'b0}};
      w_q        <= {LOC_SIZE{1'b0}};
      h_q        <= {LOC_SIZE{1'b0}};
      bu_q       <= 1'b0;
      stride_q   <= {ADDR_W{1'b0}};
      row_addr_q <= {ADDR_W{1'b0}};
      pix_off_q  <= {ADDR_W{1'b0}};
      done_q     <= 1'b0;
      frame_q    <= {LOC_SIZE{1'b0}};
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      bu_q       <= bu_d;
      stride_q   <= stride_d;
      row_addr_q <= row_addr_d;
      pix_off_q  <= pix_off_d;
      done_q     <= done_d;
      frame_q    <= frame_d;
    end
  end

  // Byte capture one cycle after each read, independent of en so no read is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= {DATA_W{1'b0}};
      rd_pend_q <= 1'b0;
      rd_k_q    <= 2'd0;
    end else begin
      rd_pend_q <= mem_rd;
      rd_k_q    <= k_q;
      if (rd_pend_q) begin
        data_q[int'(rd_k_q)*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
      end
    end
  end

  assign mem_rd    = (state_q == S_FETCH) && en;
  assign mem_addr  = mem_rd ? (row_addr_q + pix_off_q + ADDR_W'(k_q)) : {ADDR_W{1'b0}};
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = data_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_hsync = out_valid && (x_q == {LOC_SIZE{1'b0}});
  assign out_vsync = out_valid && (x_q == {LOC_SIZE{1'b0}}) && (y_q == {LOC_SIZE{1'b0}});
  assign out_last  = out_valid && last_s;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign frame     = frame_q;

endmodule
